// File: rtl/ffn_class_collector.sv
// ffn_class_collector: gathers one frame of serial FFN class scores into a
// packed vector, tracks the running argmax, and publishes both behind a
// valid/ack handshake. Published outputs hold until the next frame completes.
module ffn_class_collector #(
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CLASS_BITS  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [OUT_WIDTH-1:0]             in_data,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [OUT_WIDTH*NUM_CLASSES-1:0] out_data,
  output logic [CLASS_BITS-1:0]            out_class,
  output logic                             out_valid,
  input  logic                             out_ack,
  output logic                             frame_err
);

  localparam int unsigned VEC_W = OUT_WIDTH * NUM_CLASSES;
  localparam logic [CLASS_BITS-1:0] LAST_LANE = CLASS_BITS'(NUM_CLASSES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                r_state;
  logic [CLASS_BITS-1:0] r_idx;
  logic [VEC_W-1:0]      r_shadow;
  logic [OUT_WIDTH-1:0]  r_max_val;
  logic [CLASS_BITS-1:0] r_max_idx;
  logic [VEC_W-1:0]      r_out_data;
  logic [CLASS_BITS-1:0] r_out_class;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic                  r_frame_err;

  logic                  w_accept;
  logic                  w_last_lane;
  logic                  w_complete;
  logic                  w_frame_bad;
  logic                  w_take_max;
  logic [OUT_WIDTH-1:0]  w_max_val_nxt;
  logic [CLASS_BITS-1:0] w_max_idx_nxt;
  logic [VEC_W-1:0]      w_merged;

  // Beat acceptance, framing checks, running argmax and lane merge for this beat.
  always_comb begin
    w_accept      = in_valid && (r_state == COLLECT);
    w_last_lane   = (r_idx == LAST_LANE);
    w_complete    = w_accept && (w_last_lane || in_last);
    // Short frame (last before final lane) or missing last (final lane without last).
    w_frame_bad   = w_accept && (w_last_lane != in_last);
    w_take_max    = (r_idx == '0) || (in_data > r_max_val);
    w_max_val_nxt = w_take_max ? in_data : r_max_val;
    w_max_idx_nxt = w_take_max ? r_idx : r_max_idx;
    w_merged      = r_shadow;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      if (r_idx == CLASS_BITS'(i)) begin
        w_merged[i*OUT_WIDTH +: OUT_WIDTH] = in_data;
      end
    end
  end

  // COLLECT/HOLD state machine with all handshake and published outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_max_val   <= '0;
      r_max_idx   <= '0;
      r_out_data  <= '0;
      r_out_class <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            if (w_complete) begin
              r_out_data  <= w_merged;
              r_out_class <= w_max_idx_nxt;
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_idx       <= '0;
              r_shadow    <= '0;
              r_max_val   <= '0;
              r_max_idx   <= '0;
            end else begin
              r_shadow    <= w_merged;
              r_max_val   <= w_max_val_nxt;
              r_max_idx   <= w_max_idx_nxt;
              r_idx       <= r_idx + CLASS_BITS'(1);
            end
          end
        end
        HOLD: begin
          if (out_ack) begin
            r_state     <= COLLECT;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_class = r_out_class;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ffn_class_collector.sv
// tb_ffn_class_collector: randomized and directed checks of the class-score
// collector against a frame-level reference model (argmax by scan, lowest
// index wins ties; unfilled lanes publish as zero).
module tb_ffn_class_collector;

  localparam int OW = 16;
  localparam int NC = 10;
  localparam int CB = 4;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic [OW-1:0]  in_data;
  logic           in_last;
  logic           in_ready;
  logic [OW*NC-1:0] out_data;
  logic [CB-1:0]  out_class;
  logic           out_valid;
  logic           out_ack;
  logic           frame_err;

  int total;
  int bad;

  logic [OW-1:0]    fr [NC];
  logic [OW*NC-1:0] exp_data;
  int               exp_class;
  bit               exp_err;

  ffn_class_collector #(.OUT_WIDTH(OW), .NUM_CLASSES(NC), .CLASS_BITS(CB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_class(out_class), .out_valid(out_valid), .out_ack(out_ack),
    .frame_err(frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives n consecutive beats (optionally with idle gaps); updates the model when the frame completes.
  task automatic send_frame(input int n, input bit last_final, input bit gaps);
    int g;
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clock);
          in_valid = 1'b0;
          in_data  = OW'($urandom);
          in_last  = 1'($urandom);
        end
      end
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = fr[b];
      in_last  = (b == n - 1) ? last_final : 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (n == NC || last_final) begin
      exp_data  = '0;
      exp_class = 0;
      for (int b = 0; b < n; b++) exp_data[b*OW +: OW] = fr[b];
      for (int b = 1; b < n; b++) if (fr[b] > fr[exp_class]) exp_class = b;
      if ((n < NC && last_final) || (n == NC && !last_final)) exp_err = 1'b1;
    end
  endtask

  // Pulses out_ack for one clock edge.
  task automatic do_ack();
    @(negedge clock);
    out_ack = 1'b1;
    @(negedge clock);
    out_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got %h want 0", out_data); end
    total++; if (out_class !== '0) begin bad++; $display("FAIL rst_class got %0d want 0", out_class); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", frame_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", in_ready); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL post_rst ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_full_frame();
    logic [OW-1:0] s [NC] = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd8, 16'd7, 16'd4, 16'd6};
    fr = s;
    send_frame(NC, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got %b want 1", out_valid); end
    total++; if (out_class !== CB'(2)) begin bad++; $display("FAIL full_class got %0d want 2", out_class); end
    total++; if (out_data[2*OW +: OW] !== 16'd9) begin bad++; $display("FAIL full_lane2 got %0d want 9", out_data[2*OW +: OW]); end
    total++; if (out_data !== exp_data) begin bad++; $display("FAIL full_data got %h want %h", out_data, exp_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL full_err got %b want 0", frame_err); end
    repeat (3) begin
      @(negedge clock);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready got %b want 0", in_ready); end
    end
    do_ack();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL full_ack ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_ties();
    logic [OW-1:0] s [NC] = '{16'd7, 16'd7, 16'd3, 16'd7, 16'd1, 16'd2, 16'd0, 16'd5, 16'd6, 16'd4};
    fr = s;
    send_frame(NC, 1'b1, 1'b0);
    total++; if (out_class !== CB'(0)) begin bad++; $display("FAIL tie_class got %0d want 0", out_class); end
    do_ack();
    for (int i = 0; i < NC; i++) fr[i] = 16'hFFFF;
    send_frame(NC, 1'b1, 1'b0);
    total++; if (out_class !== CB'(0)) begin bad++; $display("FAIL ffff_class got %0d want 0", out_class); end
    total++; if (out_data !== exp_data) begin bad++; $display("FAIL ffff_data got %h want %h", out_data, exp_data); end
  endtask

  task automatic test_backpressure();
    // Entered in HOLD from the previous frame.
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      in_valid = ~in_valid;
      in_data  = OW'($urandom);
      in_last  = 1'($urandom);
      total++;
      if (out_data !== exp_data || out_class !== CB'(exp_class) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d class=%0d valid=%b ready=%b want class=%0d valid=1 ready=0", c, out_class, out_valid, in_ready, exp_class);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ack  = 1'b1;
    @(posedge clock);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ack_ready got %b want 1", in_ready); end
    @(negedge clock);
    out_ack = 1'b0;
    for (int i = 0; i < NC; i++) fr[i] = OW'(i * 3 + 1);
    send_frame(NC, 1'b1, 1'b0);
    total++; if (out_data !== exp_data || out_class !== CB'(9)) begin bad++; $display("FAIL bp_next got class %0d data %h want 9 %h", out_class, out_data, exp_data); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < NC; i++) fr[i] = OW'($urandom_range(60, 200));
    send_frame(5, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0 || out_data !== exp_data) begin bad++; $display("FAIL mid_partial valid=%b data=%h want 0 %h", out_valid, out_data, exp_data); end
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_class !== '0 || frame_err !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst valid=%b data=%h class=%0d err=%b ready=%b want 0 0 0 0 1", out_valid, out_data, out_class, frame_err, in_ready);
    end
    exp_data = '0; exp_class = 0; exp_err = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < NC - 1; i++) fr[i] = OW'($urandom_range(0, 49));
    fr[NC-1] = 16'd50;
    send_frame(NC, 1'b1, 1'b0);
    total++; if (out_class !== CB'(9)) begin bad++; $display("FAIL mid_clean_class got %0d want 9", out_class); end
    total++; if (out_data !== exp_data || frame_err !== 1'b0) begin bad++; $display("FAIL mid_clean data=%h err=%b want %h 0", out_data, frame_err, exp_data); end
    do_ack();
  endtask

  task automatic test_missing_last();
    for (int i = 0; i < NC; i++) fr[i] = OW'($urandom);
    send_frame(NC, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || frame_err !== 1'b1) begin bad++; $display("FAIL miss_last valid=%b err=%b want 1 1", out_valid, frame_err); end
    total++; if (out_data !== exp_data || out_class !== CB'(exp_class)) begin bad++; $display("FAIL miss_data class=%0d want %0d", out_class, exp_class); end
    do_ack();
    for (int i = 0; i < NC; i++) fr[i] = OW'(100 - i);
    send_frame(NC, 1'b1, 1'b0);
    total++; if (out_data !== exp_data || out_class !== CB'(0)) begin bad++; $display("FAIL miss_next class=%0d data=%h want 0 %h", out_class, out_data, exp_data); end
    do_ack();
  endtask

  task automatic test_short_frame();
    @(negedge clock);
    reset = 1'b0;
    exp_data = '0; exp_class = 0; exp_err = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    fr[0] = 16'd1; fr[1] = 16'd2; fr[2] = 16'd40; fr[3] = 16'd3;
    send_frame(4, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_class !== CB'(2)) begin bad++; $display("FAIL short_class valid=%b class=%0d want 1 2", out_valid, out_class); end
    total++; if (out_data[OW*NC-1:4*OW] !== '0) begin bad++; $display("FAIL short_zero got %h want 0", out_data[OW*NC-1:4*OW]); end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err got %b want 1", frame_err); end
    do_ack();
    for (int i = 0; i < NC; i++) fr[i] = OW'($urandom);
    send_frame(NC, 1'b1, 1'b0);
    total++; if (frame_err !== 1'b1 || out_data !== exp_data) begin bad++; $display("FAIL short_sticky err=%b want 1", frame_err); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] d [33];
    int ec;
    for (int k = 0; k < 33; k++) d[k] = OW'($urandom_range(0, 500));
    for (int k = 0; k < 33; k++) begin
      @(negedge clock);
      out_ack  = 1'b1;
      in_valid = 1'b1;
      in_data  = d[k];
      in_last  = (k % 11 == 9);
      @(posedge clock);
      #1;
      total++;
      if (out_valid !== (k % 11 == 9)) begin bad++; $display("FAIL b2b_valid k=%0d got %b want %b", k, out_valid, (k % 11 == 9)); end
      if (k % 11 == 9) begin
        ec = k - 9;
        for (int j = k - 8; j <= k; j++) if (d[j] > d[ec]) ec = j;
        total++;
        if (out_class !== CB'(ec - (k - 9))) begin bad++; $display("FAIL b2b_class k=%0d got %0d want %0d", k, out_class, ec - (k - 9)); end
      end
    end
    @(negedge clock);
    out_ack  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_end_ready got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    int n;
    bit lf;
    for (int f = 0; f < 15; f++) begin
      n  = $urandom_range(1, NC);
      lf = (n < NC) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < NC; i++) fr[i] = ($urandom_range(0, 1) == 1) ? OW'($urandom_range(0, 3)) : OW'($urandom);
      send_frame(n, lf, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_data || out_class !== CB'(exp_class) || frame_err !== exp_err) begin
        bad++;
        $display("FAIL rand f=%0d n=%0d valid=%b class=%0d err=%b want 1 %0d %b", f, n, out_valid, out_class, frame_err, exp_class, exp_err);
      end
      do_ack();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ack = 1'b0;
    exp_data = '0; exp_class = 0; exp_err = 1'b0;
    test_reset();
    test_full_frame();
    test_ties();
    test_backpressure();
    test_reset_mid_frame();
    test_missing_last();
    test_short_frame();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
